// File: rtl/sat_narrow_stream.sv
// Narrows an IN_W-bit sample stream to OUT_W bits with optional saturation behind a 2-entry skid
// buffer. Define SAT_NARROW_OVF_CNT_EN to add the ovf_clr/ovf_count overflow counter.
module sat_narrow_stream #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 4,
    parameter int IN_SIGNED  = 1,
    parameter int OUT_SIGNED = 1,
    parameter int SAT        = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf
`ifdef SAT_NARROW_OVF_CNT_EN
    ,
    input  logic             ovf_clr,
    output logic [7:0]       ovf_count
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    localparam int LO_I = (OUT_SIGNED != 0) ? -(1 << (OUT_W - 1)) : 0;
    localparam int HI_I = (OUT_SIGNED != 0) ? (1 << (OUT_W - 1)) - 1 : (1 << OUT_W) - 1;
    localparam logic signed [IN_W:0] LO_V = LO_I[IN_W:0];
    localparam logic signed [IN_W:0] HI_V = HI_I[IN_W:0];

    logic [1:0]       r_state;
    logic             r_in_ready;
    logic [OUT_W-1:0] r_out_data;
    logic             r_out_ovf;
    logic [OUT_W-1:0] r_skid_data;
    logic             r_skid_ovf;

    logic signed [IN_W:0] w_v;
    logic                 w_below;
    logic                 w_above;
    logic [OUT_W-1:0]     w_clamp;
    logic [OUT_W-1:0]     w_nar_data;
    logic                 w_nar_ovf;
    logic                 w_in_xfer;
    logic                 w_out_xfer;
    logic [1:0]           w_state_nxt;
    logic                 w_load_out;
    logic                 w_load_skid;
    logic                 w_out_from_skid;

    // Bounds fit in IN_W+1 signed bits because OUT_W < IN_W.
    always_comb begin
        w_v        = (IN_SIGNED != 0) ? {in_data[IN_W-1], in_data} : {1'b0, in_data};
        w_below    = w_v < LO_V;
        w_above    = w_v > HI_V;
        w_clamp    = w_below ? LO_V[OUT_W-1:0] : (w_above ? HI_V[OUT_W-1:0] : in_data[OUT_W-1:0]);
        w_nar_data = (SAT != 0) ? w_clamp : in_data[OUT_W-1:0];
        w_nar_ovf  = w_below || w_above;
    end

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = out_valid && out_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_load_out      = 1'b0;
        w_load_skid     = 1'b0;
        w_out_from_skid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = ST_ONE;
                    w_load_out  = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_load_out = 1'b1;
                end else if (w_in_xfer) begin
                    w_state_nxt = ST_TWO;
                    w_load_skid = 1'b1;
                end else if (w_out_xfer) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt     = ST_ONE;
                    w_out_from_skid = 1'b1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b0;
            r_out_data  <= '0;
            r_out_ovf   <= 1'b0;
            r_skid_data <= '0;
            r_skid_ovf  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
            if (w_load_out) begin
                r_out_data <= w_nar_data;
                r_out_ovf  <= w_nar_ovf;
            end else if (w_out_from_skid) begin
                r_out_data <= r_skid_data;
                r_out_ovf  <= r_skid_ovf;
            end
            if (w_load_skid) begin
                r_skid_data <= w_nar_data;
                r_skid_ovf  <= w_nar_ovf;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_out_data;
    assign out_ovf   = r_out_ovf;

`ifdef SAT_NARROW_OVF_CNT_EN
    logic [7:0] r_ovf_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_count <= 8'd0;
        end else if (ovf_clr) begin
            r_ovf_count <= 8'd0;
        end else if (w_out_xfer && r_out_ovf && (r_ovf_count != 8'hFF)) begin
            r_ovf_count <= r_ovf_count + 8'd1;
        end
    end

    assign ovf_count = r_ovf_count;
`endif

endmodule

// File: doc/sat_narrow_stream.md
SAT_NARROW_STREAM -- requirements
Module: sat_narrow_stream

Interface
REQ-001 SHALL have parameter IN_W, default 8, input sample width.
REQ-002 SHALL have parameter OUT_W, default 4, output sample width; legal only if OUT_W < IN_W.
REQ-003 SHALL have parameter IN_SIGNED, default 1, 1 = input is two's complement, 0 = input is unsigned.
REQ-004 SHALL have parameter OUT_SIGNED, default 1, 1 = output range is signed, 0 = output range is unsigned.
REQ-005 SHALL have parameter SAT, default 1, 1 = clamp out-of-range values, 0 = truncate to the low OUT_W bits.
REQ-006 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-007 SHALL have port rst_n, input, width 1, asynchronous active-low reset.
REQ-008 SHALL have port in_valid, input, width 1, input beat valid.
REQ-009 SHALL have port in_ready, output, width 1, block can accept an input beat.
REQ-010 SHALL have port in_data, input, width IN_W, input sample.
REQ-011 SHALL have port out_valid, output, width 1, output beat valid.
REQ-012 SHALL have port out_ready, input, width 1, sink accepts the output beat.
REQ-013 SHALL have port out_data, output, width OUT_W, narrowed sample.
REQ-014 SHALL have port out_ovf, output, width 1, the beat's input was outside the output range.
REQ-015 SHALL have ports ovf_clr (input, width 1, synchronous clear) and ovf_count (output, width 8, overflow count) only when SAT_NARROW_OVF_CNT_EN is defined.

Function
REQ-016 SHALL interpret in_data as a value v: sign-extended if IN_SIGNED=1, zero-extended if IN_SIGNED=0, then evaluated at IN_W+1 bits signed.
REQ-017 SHALL use output range [-2^(OUT_W-1), 2^(OUT_W-1)-1] when OUT_SIGNED=1 and [0, 2^OUT_W-1] when OUT_SIGNED=0.
REQ-018 SHALL set out_ovf=1 exactly when v is outside the output range, independent of SAT.
REQ-019 SHALL, with SAT=1, output the nearest range bound for an out-of-range v and the value v otherwise.
REQ-020 SHALL, with SAT=0, output in_data[OUT_W-1:0].
REQ-021 SHALL transfer an input beat only on a clk edge where in_valid=1 and in_ready=1.
REQ-022 SHALL transfer an output beat only on a clk edge where out_valid=1 and out_ready=1.
REQ-023 SHALL assert out_valid for an accepted beat at the first clk edge after acceptance, with registered out_data and out_ovf (1-cycle latency).
REQ-024 SHALL contain a 2-entry skid buffer with states EMPTY, ONE (output register full) and TWO (output register and skid register full).
REQ-025 SHALL drive in_ready = (state != TWO) directly from a register, with no combinational path from out_ready.
REQ-026 SHALL make these state transitions: EMPTY->ONE on input transfer; ONE->TWO on input transfer without output transfer; ONE->EMPTY on output transfer without input transfer; TWO->ONE on output transfer. Other cases hold the state.
REQ-027 SHALL, on simultaneous input and output transfer in state ONE, load the new beat into the output register and stay in ONE, sustaining one beat per cycle.
REQ-028 SHALL deliver beats in acceptance order, never drop or duplicate a beat, and hold out_data and out_ovf stable while out_valid=1 and out_ready=0.

Reset
REQ-029 SHALL, while rst_n=0 and asynchronously, force state EMPTY, out_valid=0, out_data=0, out_ovf=0 and in_ready=0.
REQ-030 SHALL set in_ready=1 at the first clk edge after rst_n deasserts.
REQ-031 SHALL discard all buffered beats on reset asserted mid-transfer.
REQ-032 SHALL clear ovf_count to 0 on reset when SAT_NARROW_OVF_CNT_EN is defined.

Configuration
REQ-033 SHALL, when SAT_NARROW_OVF_CNT_EN is defined, increment ovf_count on each output transfer with out_ovf=1, saturating at 255.
REQ-034 SHALL clear ovf_count to 0 when ovf_clr=1 at a clk edge; a clear wins over a simultaneous increment.
REQ-035 SHALL, when SAT_NARROW_OVF_CNT_EN is undefined, omit ovf_clr, ovf_count and the counter logic, with all other behaviour unchanged.

Verification
REQ-036 SHALL check, with default parameters: in_data=8'hFD -> out_data=4'hD and out_ovf=0, one cycle after acceptance.
REQ-037 SHALL check, with IN_SIGNED=0 and OUT_SIGNED=1: in_data=8'h0D -> SAT=1 gives 4'h7 with out_ovf=1, and SAT=0 gives 4'hD with out_ovf=1.
REQ-038 SHALL check, with IN_SIGNED=1, OUT_SIGNED=0, SAT=1: 8'h80 -> 4'h0 with ovf=1, and 8'h7F -> 4'hF with ovf=1.
REQ-039 SHALL check backpressure: out_ready=0 for 3 cycles while 3 beats are offered -> in_ready=0 after the 2nd beat is accepted, and after out_ready=1 the order is beat1, beat2, beat3.
REQ-040 SHALL check reset: rst_n pulsed low in state TWO -> out_valid=0 immediately, and no stale beat appears after release.
REQ-041 SHALL check, with SAT_NARROW_OVF_CNT_EN defined: 300 overflowing beats -> ovf_count=255; then ovf_clr asserted together with an overflowing transfer -> ovf_count=0.
